k2_prog_mem: RTL and testbench

- Parametrised, run-time loadable instruction memory for the K2 core.
- Replaces fixed-contents program ROMs with NUM_BANKS writable program banks.
- Banks are filled through a valid/ready load stream; the fetch port gives a registered instruction word one cycle after the address.
- Sits between the program loader/testbench and the K2 fetch stage.

---
 rtl/k2_prog_mem.sv | 237 +++++++++++++++++++++++
 tb/tb_k2_prog_mem.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/k2_prog_mem.sv
// -----------------------------------------------------------------------------
// k2_prog_mem
//
// Run-time loadable instruction memory for the K2 core. Holds NUM_BANKS
// independent program banks of DEPTH = 2**ADDR_W words each. Banks are filled
// through a valid/ready load stream and read through a registered fetch port
// with one cycle of latency.
//
// Optional feature: define K2_PROG_MEM_CHECKSUM_EN to add the load_csum input.
// A running XOR of the accepted words is then compared against load_csum when
// load_last is accepted. A mismatch flags load_err and leaves the bank empty.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous, active-high reset
//   rd_en       fetch request
//   rd_bank     bank to fetch from
//   rd_addr     fetch address (PC)
//   inst        fetched instruction, registered
//   inst_valid  inst holds the result of the previous cycle's fetch
//   load_start  one-cycle pulse that begins loading bank load_bank
//   load_bank   target bank, sampled with load_start
//   load_valid  load_data is valid
//   load_data   instruction word to store
//   load_last   marks the final word, qualified by load_valid
//   load_csum   expected XOR of all words (checksum build only)
//   load_ready  a word is accepted this cycle
//   busy        a load is in progress
//   load_done   one-cycle pulse when a load completes cleanly
//   load_err    sticky error flag, cleared by the next load_start or rst
//   prog_len    stored length of rd_bank
// -----------------------------------------------------------------------------
module k2_prog_mem #(
    parameter int                INST_W    = 8,
    parameter int                ADDR_W    = 4,
    parameter int                NUM_BANKS = 4,
    parameter int                BANK_W    = 2,
    parameter logic [INST_W-1:0] FILL_INST = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [BANK_W-1:0] rd_bank,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [INST_W-1:0] inst,
    output logic              inst_valid,
    input  logic              load_start,
    input  logic [BANK_W-1:0] load_bank,
    input  logic              load_valid,
    input  logic [INST_W-1:0] load_data,
    input  logic              load_last,
`ifdef K2_PROG_MEM_CHECKSUM_EN
    input  logic [INST_W-1:0] load_csum,
`endif
    output logic              load_ready,
    output logic              busy,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   prog_len
);

    // state | meaning
    // IDLE  | no load active; waiting for load_start
    // LOAD  | accepting words into the latched bank
    // DONE  | one-cycle load_done pulse after a clean load_last
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int              DEPTH    = 2 ** ADDR_W;
    localparam logic [BANK_W:0] BANK_LIM = (BANK_W + 1)'(NUM_BANKS);
    localparam logic [ADDR_W:0] FULL_LEN = (ADDR_W + 1)'(DEPTH);

    state_t              state;
    state_t              state_nxt;
    logic [BANK_W-1:0]   bank_q;
    logic [ADDR_W-1:0]   wptr;
    logic [INST_W-1:0]   mem   [NUM_BANKS][DEPTH];
    logic [ADDR_W:0]     len_q [NUM_BANKS];

    logic                accept;
    logic                start_ok;
    logic                start_bad;
    logic                fin_ok;
    logic                fin_bad;
    logic                ovf;
    logic                csum_ok;
    logic                rd_bank_ok;
    logic                load_bank_ok;
    logic [INST_W-1:0]   fetch_word;

    assign rd_bank_ok   = ({1'b0, rd_bank} < BANK_LIM);
    assign load_bank_ok = ({1'b0, load_bank} < BANK_LIM);

    // ---------------------------------------------------------------- checksum
`ifdef K2_PROG_MEM_CHECKSUM_EN
    logic [INST_W-1:0] csum_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            csum_q <= '0;
        end else if (start_ok) begin
            csum_q <= '0;
        end else if (accept) begin
            csum_q <= csum_q ^ load_data;
        end
    end

    // Includes the word arriving with load_last, which is not yet in csum_q.
    assign csum_ok = ((csum_q ^ load_data) == load_csum);
`else
    assign csum_ok = 1'b1;
`endif

    // --------------------------------------------------------------------- FSM
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        start_ok  = 1'b0;
        start_bad = 1'b0;
        fin_ok    = 1'b0;
        fin_bad   = 1'b0;
        ovf       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (load_start) begin
                    if (load_bank_ok) begin
                        start_ok  = 1'b1;
                        state_nxt = ST_LOAD;
                    end else begin
                        start_bad = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                accept = load_valid;
                if (load_valid) begin
                    if (load_last) begin
                        if (csum_ok) begin
                            fin_ok    = 1'b1;
                            state_nxt = ST_DONE;
                        end else begin
                            fin_bad   = 1'b1;
                            state_nxt = ST_IDLE;
                        end
                    end else if (wptr == '1) begin
                        // Bank is full and the stream has not ended.
                        ovf       = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign load_ready = (state == ST_LOAD);
    assign busy       = (state == ST_LOAD);
    assign load_done  = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            bank_q   <= '0;
            wptr     <= '0;
            load_err <= 1'b0;
            for (int i = 0; i < NUM_BANKS; i++) begin
                len_q[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            if (start_ok) begin
                bank_q           <= load_bank;
                wptr             <= '0;
                load_err         <= 1'b0;
                // Empty the bank up front so a partial load never exposes
                // the previous program.
                len_q[load_bank] <= '0;
            end
            if (start_bad) begin
                load_err <= 1'b1;
            end
            if (accept) begin
                wptr <= wptr + ADDR_W'(1);
            end
            if (fin_ok) begin
                len_q[bank_q] <= {1'b0, wptr} + (ADDR_W + 1)'(1);
            end
            if (fin_bad) begin
                load_err      <= 1'b1;
                len_q[bank_q] <= '0;
            end
            if (ovf) begin
                load_err      <= 1'b1;
                len_q[bank_q] <= FULL_LEN;
            end
        end
    end

    // Array contents are deliberately not reset; len_q gates visibility.
    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            mem[bank_q][wptr] <= load_data;
        end
    end

    // ------------------------------------------------------------------- fetch
    always_comb begin
        fetch_word = FILL_INST;
        if (rd_bank_ok && !(state == ST_LOAD && rd_bank == bank_q)
            && ({1'b0, rd_addr} < len_q[rd_bank])) begin
            fetch_word = mem[rd_bank][rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inst       <= FILL_INST;
            inst_valid <= 1'b0;
        end else begin
            inst_valid <= rd_en;
            if (rd_en) begin
                inst <= fetch_word;
            end
        end
    end

    assign prog_len = rd_bank_ok ? len_q[rd_bank] : '0;

endmodule

// File: tb/tb_k2_prog_mem.sv
module tb_k2_prog_mem;

    logic       clk = 1'b0;
    logic       rst;
    logic       rd_en;
    logic [1:0] rd_bank;
    logic [3:0] rd_addr;
    logic [7:0] inst;
    logic       inst_valid;
    logic       load_start;
    logic [1:0] load_bank;
    logic       load_valid;
    logic [7:0] load_data;
    logic       load_last;
`ifdef K2_PROG_MEM_CHECKSUM_EN
    logic [7:0] load_csum;
`endif
    logic       load_ready;
    logic       busy;
    logic       load_done;
    logic       load_err;
    logic [4:0] prog_len;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] words [0:16];

    always #5 clk = ~clk;

    k2_prog_mem dut (
        .clk        (clk),
        .rst        (rst),
        .rd_en      (rd_en),
        .rd_bank    (rd_bank),
        .rd_addr    (rd_addr),
        .inst       (inst),
        .inst_valid (inst_valid),
        .load_start (load_start),
        .load_bank  (load_bank),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_last  (load_last),
`ifdef K2_PROG_MEM_CHECKSUM_EN
        .load_csum  (load_csum),
`endif
        .load_ready (load_ready),
        .busy       (busy),
        .load_done  (load_done),
        .load_err   (load_err),
        .prog_len   (prog_len)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input logic [1:0] bank);
        load_start = 1'b1;
        load_bank  = bank;
        tick();
        load_start = 1'b0;
    endtask

    task automatic test_reset;
        rst        = 1'b1;
        rd_en      = 1'b0;
        rd_bank    = 2'd0;
        rd_addr    = 4'd0;
        load_start = 1'b0;
        load_bank  = 2'd0;
        load_valid = 1'b0;
        load_data  = 8'h00;
        load_last  = 1'b0;
`ifdef K2_PROG_MEM_CHECKSUM_EN
        load_csum  = 8'h00;
`endif
        tick();
        tick();
        rst = 1'b0;
        n_cmp++; if (inst !== 8'h00) begin n_err++; $display("FAIL reset_inst got %h want 00", inst); end
        n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL reset_inst_valid got %b want 0", inst_valid); end
        n_cmp++; if (load_ready !== 1'b0) begin n_err++; $display("FAIL reset_load_ready got %b want 0", load_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (load_done !== 1'b0) begin n_err++; $display("FAIL reset_load_done got %b want 0", load_done); end
        n_cmp++; if (load_err !== 1'b0) begin n_err++; $display("FAIL reset_load_err got %b want 0", load_err); end
        n_cmp++; if (prog_len !== 5'd0) begin n_err++; $display("FAIL reset_prog_len got %0d want 0", prog_len); end
    endtask

    task automatic test_fetch_empty;
        rd_bank = 2'd0;
        for (int a = 0; a < 16; a++) begin
            rd_en   = 1'b1;
            rd_addr = 4'(a);
            tick();
            n_cmp++; if (inst !== 8'h00) begin n_err++; $display("FAIL empty_inst addr %0d got %h want 00", a, inst); end
            n_cmp++; if (inst_valid !== 1'b1) begin n_err++; $display("FAIL empty_inst_valid addr %0d got %b want 1", a, inst_valid); end
        end
        n_cmp++; if (prog_len !== 5'd0) begin n_err++; $display("FAIL empty_prog_len got %0d want 0", prog_len); end
        rd_en = 1'b0;
        tick();
        n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL empty_valid_drop got %b want 0", inst_valid); end
    endtask

    task automatic test_load_basic;
        int dones;
        words[0] = 8'h82; words[1] = 8'hF8; words[2]  = 8'h85; words[3] = 8'hF9;
        words[4] = 8'hC8; words[5] = 8'h20; words[6]  = 8'hC9; words[7] = 8'h20;
        words[8] = 8'h1D; words[9] = 8'h04; words[10] = 8'hF0;
        dones = 0;
        start_load(2'd1);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy got %b want 1", busy); end
        n_cmp++; if (load_ready !== 1'b1) begin n_err++; $display("FAIL basic_ready got %b want 1", load_ready); end
        for (int i = 0; i < 11; i++) begin
            load_valid = 1'b1;
            load_data  = words[i];
            load_last  = (i == 10);
            // A stray load_start mid-stream must be ignored.
            load_start = (i == 5);
            load_bank  = 2'd3;
            tick();
            load_start = 1'b0;
            if (load_done === 1'b1) dones++;
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_done got %b want 0", busy); end
        tick();
        if (load_done === 1'b1) dones++;
        tick();
        if (load_done === 1'b1) dones++;
        n_cmp++; if (dones !== 1) begin n_err++; $display("FAIL basic_done_count got %0d want 1", dones); end
        n_cmp++; if (load_err !== 1'b0) begin n_err++; $display("FAIL basic_err got %b want 0", load_err); end
        rd_bank = 2'd1;
        #1;
        n_cmp++; if (prog_len !== 5'd11) begin n_err++; $display("FAIL basic_prog_len got %0d want 11", prog_len); end
        for (int a = 0; a < 12; a++) begin
            logic [7:0] exp;
            exp     = (a < 11) ? words[a] : 8'h00;
            rd_en   = 1'b1;
            rd_addr = 4'(a);
            tick();
            n_cmp++; if (inst !== exp) begin n_err++; $display("FAIL basic_fetch addr %0d got %h want %h", a, inst, exp); end
        end
        rd_en = 1'b0;
    endtask

    task automatic test_backpressure;
        int i;
        int cyc;
        int dones;
        for (int k = 0; k < 16; k++) words[k] = 8'(8'hA0 + k);
        i     = 0;
        cyc   = 0;
        dones = 0;
        start_load(2'd3);
        while (i < 16 && cyc < 200) begin
            load_valid = 1'($urandom_range(0, 1));
            load_data  = load_valid ? words[i] : 8'hEE;
            load_last  = load_valid && (i == 15);
            tick();
            if (load_valid) i++;
            if (load_done === 1'b1) dones++;
            cyc++;
        end
        n_cmp++; if (i !== 16) begin n_err++; $display("FAIL bp_timeout beats %0d want 16", i); end
        load_valid = 1'b0;
        load_last  = 1'b0;
        tick();
        n_cmp++; if (dones !== 1) begin n_err++; $display("FAIL bp_done_count got %0d want 1", dones); end
        n_cmp++; if (load_err !== 1'b0) begin n_err++; $display("FAIL bp_err got %b want 0", load_err); end
        rd_bank = 2'd3;
        #1;
        n_cmp++; if (prog_len !== 5'd16) begin n_err++; $display("FAIL bp_prog_len got %0d want 16", prog_len); end
        for (int a = 0; a < 16; a++) begin
            rd_en   = 1'b1;
            rd_addr = 4'(a);
            tick();
            n_cmp++; if (inst !== words[a]) begin n_err++; $display("FAIL bp_fetch addr %0d got %h want %h", a, inst, words[a]); end
        end
        rd_en = 1'b0;
    endtask

    task automatic test_overflow;
        int dones;
        dones = 0;
        for (int k = 0; k < 17; k++) words[k] = 8'(8'h40 + k);
        start_load(2'd0);
        for (int i = 0; i < 17; i++) begin
            n_cmp++;
            if (load_ready !== (i < 16)) begin
                n_err++; $display("FAIL ovf_ready beat %0d got %b want %b", i, load_ready, (i < 16));
            end
            load_valid = 1'b1;
            load_data  = words[i];
            load_last  = 1'b0;
            tick();
            if (load_done === 1'b1) dones++;
            if (i == 15) begin
                n_cmp++; if (load_err !== 1'b1) begin n_err++; $display("FAIL ovf_err got %b want 1", load_err); end
                n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ovf_busy got %b want 0", busy); end
            end
        end
        load_valid = 1'b0;
        tick();
        n_cmp++; if (dones !== 0) begin n_err++; $display("FAIL ovf_done_count got %0d want 0", dones); end
        n_cmp++; if (load_err !== 1'b1) begin n_err++; $display("FAIL ovf_err_sticky got %b want 1", load_err); end
        rd_bank = 2'd0;
        #1;
        n_cmp++; if (prog_len !== 5'd16) begin n_err++; $display("FAIL ovf_prog_len got %0d want 16", prog_len); end
        for (int a = 0; a < 16; a++) begin
            rd_en   = 1'b1;
            rd_addr = 4'(a);
            tick();
            n_cmp++; if (inst !== words[a]) begin n_err++; $display("FAIL ovf_fetch addr %0d got %h want %h", a, inst, words[a]); end
        end
        rd_en = 1'b0;
    endtask

    task automatic test_concurrency_reset;
        start_load(2'd2);
        n_cmp++; if (load_err !== 1'b0) begin n_err++; $display("FAIL conc_err_clear got %b want 0", load_err); end
        for (int i = 0; i < 6; i++) begin
            logic [7:0] exp;
            load_valid = 1'b1;
            load_data  = 8'(8'hC0 + i);
            load_last  = 1'b0;
            rd_en      = 1'b1;
            if (i < 4) begin
                rd_bank = 2'd0;
                rd_addr = 4'(i);
                exp     = 8'(8'h40 + i);
            end else begin
                rd_bank = 2'd2;
                rd_addr = 4'(i - 4);
                exp     = 8'h00;
            end
            tick();
            n_cmp++; if (inst !== exp) begin n_err++; $display("FAIL conc_fetch beat %0d got %h want %h", i, inst, exp); end
            n_cmp++; if (inst_valid !== 1'b1) begin n_err++; $display("FAIL conc_valid beat %0d got %b want 1", i, inst_valid); end
        end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL conc_busy got %b want 1", busy); end
        rst = 1'b1;
        tick();
        rst        = 1'b0;
        load_valid = 1'b0;
        rd_en      = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", busy); end
        n_cmp++; if (load_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready got %b want 0", load_ready); end
        n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL rst_inst_valid got %b want 0", inst_valid); end
        n_cmp++; if (inst !== 8'h00) begin n_err++; $display("FAIL rst_inst got %h want 00", inst); end
        for (int b = 0; b < 4; b++) begin
            rd_bank = 2'(b);
            #1;
            n_cmp++; if (prog_len !== 5'd0) begin n_err++; $display("FAIL rst_prog_len bank %0d got %0d want 0", b, prog_len); end
        end
        tick();
    endtask

`ifdef K2_PROG_MEM_CHECKSUM_EN
    task automatic test_checksum;
        int dones;
        words[0] = 8'h12; words[1] = 8'h34; words[2] = 8'h56;
        for (int pass = 0; pass < 2; pass++) begin
            dones = 0;
            start_load(2'd1);
            for (int i = 0; i < 3; i++) begin
                load_valid = 1'b1;
                load_data  = words[i];
                load_last  = (i == 2);
                load_csum  = (pass == 0) ? 8'h70 : 8'h71;
                tick();
                if (load_done === 1'b1) dones++;
            end
            load_valid = 1'b0;
            load_last  = 1'b0;
            tick();
            rd_bank = 2'd1;
            #1;
            if (pass == 0) begin
                n_cmp++; if (dones !== 1) begin n_err++; $display("FAIL csum_ok_done got %0d want 1", dones); end
                n_cmp++; if (load_err !== 1'b0) begin n_err++; $display("FAIL csum_ok_err got %b want 0", load_err); end
                n_cmp++; if (prog_len !== 5'd3) begin n_err++; $display("FAIL csum_ok_len got %0d want 3", prog_len); end
            end else begin
                n_cmp++; if (dones !== 0) begin n_err++; $display("FAIL csum_bad_done got %0d want 0", dones); end
                n_cmp++; if (load_err !== 1'b1) begin n_err++; $display("FAIL csum_bad_err got %b want 1", load_err); end
                n_cmp++; if (prog_len !== 5'd0) begin n_err++; $display("FAIL csum_bad_len got %0d want 0", prog_len); end
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fetch_empty();
        test_load_basic();
        test_backpressure();
        test_overflow();
        test_concurrency_reset();
`ifdef K2_PROG_MEM_CHECKSUM_EN
        test_checksum();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
